// File: rtl/color_pkg.sv
// color_pkg: definitions shared by the color sequencer and core.
//   - color code constants (NONE, RED, GREEN, BLUE)
//   - filter_sel encodings {S2,S3} for the color sensors
//   - sequencer FSM state and channel enums
//   - classify(): dominant-color decision with red > green > blue tie priority
package color_pkg;

  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] RED   = 2'd1;
  localparam logic [1:0] GREEN = 2'd2;
  localparam logic [1:0] BLUE  = 2'd3;

  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_GREEN = 2'b11;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_CLEAR = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    DECIDE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CH_RED   = 2'd0,
    CH_GREEN = 2'd1,
    CH_BLUE  = 2'd2
  } chan_e;

  // Counts are zero-extended to 32 bits so one function serves any CNT_W.
  // The >= comparisons give red priority over green, and green over blue.
  function automatic logic [1:0] classify(input logic [31:0] r,
                                          input logic [31:0] g,
                                          input logic [31:0] b,
                                          input logic [31:0] min_count);
    logic [1:0]  code;
    logic [31:0] best;
    if ((r >= g) && (r >= b)) begin
      code = RED;
      best = r;
    end else if (g >= b) begin
      code = GREEN;
      best = g;
    end else begin
      code = BLUE;
      best = b;
    end
    if (best < min_count) begin
      code = NONE;
    end else begin
      code = code;
    end
    return code;
  endfunction

endpackage

// File: rtl/color_sequencer_edge_counter.sv
// color_sequencer_edge_counter: conditions one asynchronous sensor square wave
// and counts its rising edges.
//   clk_i, rst_i   clock, asynchronous active-high reset
//   sig_i          raw sensor square wave (asynchronous)
//   count_en_i     count edge pulses this cycle
//   clear_i        counter becomes 0 on the next edge
//   total_o        count including this cycle's edge (saturating at 2^CNT_W-1)
module color_sequencer_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sig_i,
  input  logic             count_en_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] total_o
);

  logic             sync1_q;
  logic             sync2_q;
  logic             prev_q;
  logic             edge_s;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] total_s;

  assign edge_s  = sync2_q & ~prev_q;
  assign total_o = total_s;

  // Saturating increment; total_s already includes the current cycle's edge so
  // the owner can capture a complete window on its last cycle.
  always_comb begin
    total_s = count_q;
    if (count_en_i && edge_s && (count_q != {CNT_W{1'b1}})) begin
      total_s = count_q + CNT_W'(1);
    end else begin
      total_s = count_q;
    end
    if (clear_i) begin
      count_d = '0;
    end else begin
      count_d = total_s;
    end
  end

  // Synchronizer, edge-detect history and counter state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/color_sequencer.sv
// color_sequencer: steps both color sensors through red, green and blue
// filters, counts each sensor's square-wave edges over a gate window per
// filter, and reports the dominant color of each sensor.
//   clk_i             system clock
//   rst_i             asynchronous active-high reset
//   object_color_i    object sensor square wave (asynchronous)
//   station_color_i   station sensor square wave (asynchronous)
//   en_i              level; high keeps scanning
//   filter_sel_o      {S2,S3} to both sensors
//   object_code_o     0 none, 1 red, 2 green, 3 blue
//   station_code_o    same encoding
//   codes_valid_o     one-cycle pulse when both codes update
//   busy_o            high whenever the sequencer is not idle
module color_sequencer
  import color_pkg::*;
#(
  parameter int GATE_CYCLES   = 500000,
  parameter int SETTLE_CYCLES = 50000,
  parameter int CNT_W         = 16,
  parameter int MIN_COUNT     = 20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       object_color_i,
  input  logic       station_color_i,
  input  logic       en_i,
  output logic [1:0] filter_sel_o,
  output logic [1:0] object_code_o,
  output logic [1:0] station_code_o,
  output logic       codes_valid_o,
  output logic       busy_o
);

  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] GATE_LAST   = 32'(GATE_CYCLES - 1);
  localparam logic [31:0] MIN_CNT     = 32'(MIN_COUNT);

  state_e           state_q, state_d;
  chan_e            chan_q, chan_d;
  logic [31:0]      timer_q, timer_d;
  logic [1:0]       filt_q, filt_d;
  logic [CNT_W-1:0] obj_r_q, obj_r_d, obj_g_q, obj_g_d, obj_b_q, obj_b_d;
  logic [CNT_W-1:0] sta_r_q, sta_r_d, sta_g_q, sta_g_d, sta_b_q, sta_b_d;
  logic [1:0]       obj_code_q, obj_code_d;
  logic [1:0]       sta_code_q, sta_code_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             cnt_en_s;
  logic             cnt_clr_s;
  logic [CNT_W-1:0] obj_total_s;
  logic [CNT_W-1:0] sta_total_s;

  // Counters run only in GATE and are zero in every cycle that is not GATE,
  // including after an abort or reset.
  assign cnt_en_s  = (state_q == GATE);
  assign cnt_clr_s = (state_d != GATE);

  color_sequencer_edge_counter #(.CNT_W(CNT_W)) u_obj_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sig_i      (object_color_i),
    .count_en_i (cnt_en_s),
    .clear_i    (cnt_clr_s),
    .total_o    (obj_total_s)
  );

  color_sequencer_edge_counter #(.CNT_W(CNT_W)) u_sta_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sig_i      (station_color_i),
    .count_en_i (cnt_en_s),
    .clear_i    (cnt_clr_s),
    .total_o    (sta_total_s)
  );

  // Next-state and output logic of the scan sequencer.
  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    timer_d    = timer_q;
    filt_d     = filt_q;
    obj_r_d    = obj_r_q;
    obj_g_d    = obj_g_q;
    obj_b_d    = obj_b_q;
    sta_r_d    = sta_r_q;
    sta_g_d    = sta_g_q;
    sta_b_d    = sta_b_q;
    obj_code_d = obj_code_q;
    sta_code_d = sta_code_q;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        filt_d  = FILT_RED;
        chan_d  = CH_RED;
        timer_d = 32'd0;
        if (en_i) begin
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end

      SETTLE, GATE: begin
        if (!en_i) begin
          // Abort: drop the partial round entirely, codes keep last values.
          state_d = IDLE;
          chan_d  = CH_RED;
          filt_d  = FILT_RED;
          timer_d = 32'd0;
          obj_r_d = '0;
          obj_g_d = '0;
          obj_b_d = '0;
          sta_r_d = '0;
          sta_g_d = '0;
          sta_b_d = '0;
        end else if ((state_q == SETTLE) && (timer_q == SETTLE_LAST)) begin
          state_d = GATE;
          timer_d = 32'd0;
        end else if ((state_q == GATE) && (timer_q == GATE_LAST)) begin
          timer_d = 32'd0;
          case (chan_q)
            CH_RED: begin
              obj_r_d = obj_total_s;
              sta_r_d = sta_total_s;
              chan_d  = CH_GREEN;
              filt_d  = FILT_GREEN;
              state_d = SETTLE;
            end
            CH_GREEN: begin
              obj_g_d = obj_total_s;
              sta_g_d = sta_total_s;
              chan_d  = CH_BLUE;
              filt_d  = FILT_BLUE;
              state_d = SETTLE;
            end
            default: begin
              obj_b_d = obj_total_s;
              sta_b_d = sta_total_s;
              state_d = DECIDE;
            end
          endcase
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      DECIDE: begin
        obj_code_d = classify(32'(obj_r_q), 32'(obj_g_q), 32'(obj_b_q), MIN_CNT);
        sta_code_d = classify(32'(sta_r_q), 32'(sta_g_q), 32'(sta_b_q), MIN_CNT);
        valid_d    = 1'b1;
        chan_d     = CH_RED;
        filt_d     = FILT_RED;
        timer_d    = 32'd0;
        if (en_i) begin
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        chan_d  = CH_RED;
        filt_d  = FILT_RED;
        timer_d = 32'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      chan_q     <= CH_RED;
      timer_q    <= 32'd0;
      filt_q     <= FILT_RED;
      obj_r_q    <= '0;
      obj_g_q    <= '0;
      obj_b_q    <= '0;
      sta_r_q    <= '0;
      sta_g_q    <= '0;
      sta_b_q    <= '0;
      obj_code_q <= NONE;
      sta_code_q <= NONE;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      timer_q    <= timer_d;
      filt_q     <= filt_d;
      obj_r_q    <= obj_r_d;
      obj_g_q    <= obj_g_d;
      obj_b_q    <= obj_b_d;
      sta_r_q    <= sta_r_d;
      sta_g_q    <= sta_g_d;
      sta_b_q    <= sta_b_d;
      obj_code_q <= obj_code_d;
      sta_code_q <= sta_code_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign filter_sel_o   = filt_q;
  assign object_code_o  = obj_code_q;
  assign station_code_o = sta_code_q;
  assign codes_valid_o  = valid_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_color_sequencer.sv
// Testbench for color_sequencer. Sensor waves are periodic with a period that
// depends on the filter currently selected; every period divides the gate
// window, so the ideal edge count per filter is exactly GATE/period.
module tb_color_sequencer;

  localparam int TG   = 1000;
  localparam int TS   = 100;
  localparam int MINC = 8;
  localparam int LAT  = 3 * (TS + TG) + 1;

  logic clk = 1'b0;
  logic rst;
  logic en_a, en_b;
  logic obj_a, sta_a, obj_b, sta_b;
  logic [1:0] fs_a, oc_a, sc_a, fs_b, oc_b, sc_b;
  logic cv_a, bz_a, cv_b, bz_b;

  int pa_o[3] = '{100, 100, 100};
  int pa_s[3] = '{100, 100, 100};
  int pb_o[3] = '{100, 100, 100};
  int pb_s[3] = '{100, 100, 100};

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] exp_o, exp_s;

  always #5 clk = ~clk;

  color_sequencer #(.GATE_CYCLES(TG), .SETTLE_CYCLES(TS), .CNT_W(16), .MIN_COUNT(MINC)) dut_a (
    .clk_i(clk), .rst_i(rst), .object_color_i(obj_a), .station_color_i(sta_a), .en_i(en_a),
    .filter_sel_o(fs_a), .object_code_o(oc_a), .station_code_o(sc_a),
    .codes_valid_o(cv_a), .busy_o(bz_a)
  );

  color_sequencer #(.GATE_CYCLES(TG), .SETTLE_CYCLES(TS), .CNT_W(4), .MIN_COUNT(MINC)) dut_b (
    .clk_i(clk), .rst_i(rst), .object_color_i(obj_b), .station_color_i(sta_b), .en_i(en_b),
    .filter_sel_o(fs_b), .object_code_o(oc_b), .station_code_o(sc_b),
    .codes_valid_o(cv_b), .busy_o(bz_b)
  );

  function automatic int chan_of(logic [1:0] f);
    case (f)
      2'b00:   return 0;
      2'b11:   return 1;
      2'b01:   return 2;
      default: return 0;
    endcase
  endfunction

  // Reference: ideal count = window/period, clipped to counter max; the first
  // largest in red, green, blue order wins; below MINC means no color.
  function automatic logic [1:0] model_code(int pr, int pg, int pb, int cmax);
    int c[3];
    int p[3];
    int best;
    p[0] = pr; p[1] = pg; p[2] = pb;
    for (int i = 0; i < 3; i++) begin
      c[i] = TG / p[i];
      if (c[i] > cmax) c[i] = cmax;
    end
    best = 0;
    for (int i = 1; i < 3; i++) if (c[i] > c[best]) best = i;
    if (c[best] < MINC) return 2'd0;
    return 2'(best + 1);
  endfunction

  // Sensor wave generators, driven on the falling edge.
  initial begin : wavegen
    int ph[4];
    int p;
    for (int i = 0; i < 4; i++) ph[i] = int'($urandom_range(0, 999));
    obj_a = 1'b0; sta_a = 1'b0; obj_b = 1'b0; sta_b = 1'b0;
    forever begin
      @(negedge clk);
      p = pa_o[chan_of(fs_a)]; ph[0] = (ph[0] + 1) % p; obj_a = (ph[0] < p / 2);
      p = pa_s[chan_of(fs_a)]; ph[1] = (ph[1] + 1) % p; sta_a = (ph[1] < p / 2);
      p = pb_o[chan_of(fs_b)]; ph[2] = (ph[2] + 1) % p; obj_b = (ph[2] < p / 2);
      p = pb_s[chan_of(fs_b)]; ph[3] = (ph[3] + 1) % p; sta_b = (ph[3] < p / 2);
    end
  end

  task automatic set_periods_a(int o_r, int o_g, int o_b, int s_r, int s_g, int s_b);
    pa_o[0] = o_r; pa_o[1] = o_g; pa_o[2] = o_b;
    pa_s[0] = s_r; pa_s[1] = s_g; pa_s[2] = s_b;
    exp_o = model_code(o_r, o_g, o_b, 65535);
    exp_s = model_code(s_r, s_g, s_b, 65535);
  endtask

  // Raise en on DUT A and return cycles from first busy cycle to codes_valid.
  task automatic run_round_a(output int lat, output logic [1:0] fs_first);
    int k;
    lat = -1;
    fs_first = 2'b10;
    en_a = 1'b1;
    k = 0;
    while (!bz_a && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!bz_a) return;
    fs_first = fs_a;
    for (int i = 1; i <= 4000; i++) begin
      @(negedge clk);
      if (cv_a) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic idle_a;
    en_a = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (fs_a !== 2'b00) $display("FAIL reset_filter_sel: got %b want 00", fs_a); else n_pass++;
    n_checks++; if (oc_a !== 2'd0) $display("FAIL reset_object_code: got %0d want 0", oc_a); else n_pass++;
    n_checks++; if (sc_a !== 2'd0) $display("FAIL reset_station_code: got %0d want 0", sc_a); else n_pass++;
    n_checks++; if (cv_a !== 1'b0) $display("FAIL reset_codes_valid: got %b want 0", cv_a); else n_pass++;
    n_checks++; if (bz_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", bz_a); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sequence;
    int lat, k, bad;
    logic [1:0] fs0, want;
    set_periods_a(100, 100, 100, 100, 100, 100);
    run_round_a(lat, fs0);
    // run_round_a ran a full round; start a fresh one and reset mid green GATE
    en_a = 1'b1;
    k = 0;
    while (!bz_a && k < 10) begin @(negedge clk); k++; end
    repeat (TS + TG + TS + 500) @(negedge clk);
    n_checks++; if (fs_a !== 2'b11) $display("FAIL pre_reset_green: got %b want 11", fs_a); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (fs_a !== 2'b00) $display("FAIL async_reset_filter: got %b want 00", fs_a); else n_pass++;
    n_checks++; if (bz_a !== 1'b0) $display("FAIL async_reset_busy: got %b want 0", bz_a); else n_pass++;
    n_checks++; if (oc_a !== 2'd0 || sc_a !== 2'd0) $display("FAIL async_reset_codes: got %0d/%0d want 0/0", oc_a, sc_a); else n_pass++;
    n_checks++; if (cv_a !== 1'b0) $display("FAIL async_reset_valid: got %b want 0", cv_a); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (!bz_a && k < 10) begin @(negedge clk); k++; end
    bad = 0;
    lat = -1;
    for (int i = 0; i < 3400; i++) begin
      if (i < 3 * (TS + TG)) begin
        want = (i < TS + TG) ? 2'b00 : ((i < 2 * (TS + TG)) ? 2'b11 : 2'b01);
        if (fs_a !== want) bad++;
      end
      if (cv_a && lat < 0) lat = i;
      if (lat >= 0) break;
      @(negedge clk);
    end
    n_checks++; if (bad != 0) $display("FAIL filter_sequence: got %0d wrong cycles want 0", bad); else n_pass++;
    n_checks++; if (lat != LAT) $display("FAIL seq_latency: got %0d want %0d", lat, LAT); else n_pass++;
    n_checks++; if (oc_a !== exp_o || sc_a !== exp_s) $display("FAIL seq_codes: got %0d/%0d want %0d/%0d", oc_a, sc_a, exp_o, exp_s); else n_pass++;
    idle_a();
  endtask

  task automatic test_dominant;
    int lat;
    logic [1:0] fs0;
    set_periods_a(20, 100, 100, 100, 20, 100);
    run_round_a(lat, fs0);
    n_checks++; if (lat != LAT) $display("FAIL dominant_latency: got %0d want %0d", lat, LAT); else n_pass++;
    n_checks++; if (oc_a !== exp_o) $display("FAIL dominant_object: got %0d want %0d", oc_a, exp_o); else n_pass++;
    n_checks++; if (sc_a !== exp_s) $display("FAIL dominant_station: got %0d want %0d", sc_a, exp_s); else n_pass++;
    @(negedge clk);
    n_checks++; if (cv_a !== 1'b0) $display("FAIL valid_one_cycle: got %b want 0", cv_a); else n_pass++;
    idle_a();
  endtask

  task automatic test_none;
    int lat;
    logic [1:0] fs0;
    set_periods_a(200, 200, 200, 200, 200, 200);
    run_round_a(lat, fs0);
    n_checks++; if (lat != LAT) $display("FAIL none_valid_pulse: got %0d want %0d", lat, LAT); else n_pass++;
    n_checks++; if (oc_a !== exp_o || sc_a !== exp_s) $display("FAIL none_codes: got %0d/%0d want %0d/%0d", oc_a, sc_a, exp_o, exp_s); else n_pass++;
    idle_a();
  endtask

  task automatic test_tie;
    int lat;
    logic [1:0] fs0;
    set_periods_a(25, 25, 100, 100, 25, 25);
    run_round_a(lat, fs0);
    n_checks++; if (oc_a !== exp_o) $display("FAIL tie_red_green: got %0d want %0d", oc_a, exp_o); else n_pass++;
    n_checks++; if (sc_a !== exp_s) $display("FAIL tie_green_blue: got %0d want %0d", sc_a, exp_s); else n_pass++;
    idle_a();
  endtask

  task automatic test_min_boundary;
    int lat;
    logic [1:0] fs0;
    // object: blue count exactly MINC; station: best count 5, below MINC
    set_periods_a(250, 250, 125, 250, 200, 250);
    run_round_a(lat, fs0);
    n_checks++; if (oc_a !== exp_o) $display("FAIL min_count_equal: got %0d want %0d", oc_a, exp_o); else n_pass++;
    n_checks++; if (sc_a !== exp_s) $display("FAIL min_count_below: got %0d want %0d", sc_a, exp_s); else n_pass++;
    idle_a();
  endtask

  task automatic test_abort;
    int lat, k, seen;
    logic [1:0] fs0, prev_o, prev_s;
    prev_o = exp_o;
    prev_s = exp_s;
    set_periods_a(20, 100, 100, 100, 20, 100);
    en_a = 1'b1;
    k = 0;
    while (!bz_a && k < 10) begin @(negedge clk); k++; end
    repeat (TS + TG + TS + 300) @(negedge clk);
    n_checks++; if (fs_a !== 2'b11) $display("FAIL abort_in_green: got %b want 11", fs_a); else n_pass++;
    en_a = 1'b0;
    @(negedge clk);
    n_checks++; if (bz_a !== 1'b0) $display("FAIL abort_busy: got %b want 0", bz_a); else n_pass++;
    n_checks++; if (fs_a !== 2'b00) $display("FAIL abort_filter: got %b want 00", fs_a); else n_pass++;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (cv_a) seen++;
      @(negedge clk);
    end
    n_checks++; if (seen != 0) $display("FAIL abort_no_valid: got %0d pulses want 0", seen); else n_pass++;
    n_checks++; if (oc_a !== prev_o || sc_a !== prev_s) $display("FAIL abort_codes_hold: got %0d/%0d want %0d/%0d", oc_a, sc_a, prev_o, prev_s); else n_pass++;
    run_round_a(lat, fs0);
    n_checks++; if (fs0 !== 2'b00) $display("FAIL restart_at_red: got %b want 00", fs0); else n_pass++;
    n_checks++; if (lat != LAT) $display("FAIL restart_latency: got %0d want %0d", lat, LAT); else n_pass++;
    n_checks++; if (oc_a !== exp_o || sc_a !== exp_s) $display("FAIL restart_codes: got %0d/%0d want %0d/%0d", oc_a, sc_a, exp_o, exp_s); else n_pass++;
    idle_a();
  endtask

  task automatic test_saturate;
    int k, t, t1, t2;
    // saturated counts tie; wrapped counts would pick a different color
    pb_o[0] = 5;   pb_o[1] = 4; pb_o[2] = 100;
    pb_s[0] = 100; pb_s[1] = 5; pb_s[2] = 4;
    exp_o = model_code(5, 4, 100, 15);
    exp_s = model_code(100, 5, 4, 15);
    en_b = 1'b1;
    k = 0;
    while (!bz_b && k < 10) begin @(negedge clk); k++; end
    t = 0; t1 = -1; t2 = -1;
    while (t < 7000 && t2 < 0) begin
      @(negedge clk);
      t++;
      if (cv_b) begin
        if (t1 < 0) t1 = t;
        else t2 = t;
      end
    end
    n_checks++; if (t1 != LAT) $display("FAIL sat_first_valid: got %0d want %0d", t1, LAT); else n_pass++;
    n_checks++; if (t2 - t1 != LAT) $display("FAIL back_to_back_spacing: got %0d want %0d", t2 - t1, LAT); else n_pass++;
    n_checks++; if (oc_b !== exp_o) $display("FAIL sat_object: got %0d want %0d", oc_b, exp_o); else n_pass++;
    n_checks++; if (sc_b !== exp_s) $display("FAIL sat_station: got %0d want %0d", sc_b, exp_s); else n_pass++;
    en_b = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random;
    int per[12] = '{4, 5, 8, 10, 20, 25, 40, 50, 100, 125, 200, 250};
    int q[6];
    int lat;
    logic [1:0] fs0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 6; j++) q[j] = per[$urandom_range(0, 11)];
      set_periods_a(q[0], q[1], q[2], q[3], q[4], q[5]);
      run_round_a(lat, fs0);
      n_checks++; if (lat != LAT) $display("FAIL rand_latency[%0d]: got %0d want %0d", r, lat, LAT); else n_pass++;
      n_checks++; if (oc_a !== exp_o) $display("FAIL rand_object[%0d]: got %0d want %0d periods %0d/%0d/%0d", r, oc_a, exp_o, q[0], q[1], q[2]); else n_pass++;
      n_checks++; if (sc_a !== exp_s) $display("FAIL rand_station[%0d]: got %0d want %0d periods %0d/%0d/%0d", r, sc_a, exp_s, q[3], q[4], q[5]); else n_pass++;
      idle_a();
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en_a = 1'b0;
    en_b = 1'b0;
    test_reset();
    test_sequence();
    test_dominant();
    test_none();
    test_tie();
    test_min_boundary();
    test_abort();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
